// File: rtl/perip_arbiter.sv
// Two-master round-robin arbiter/sequencer for the single-slave peripheral port.
// Each access is latched at grant, issued for one cycle, waited out for RD_LAT, then acked.
module perip_arbiter #(
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_req,
   input  logic        m0_we,
   input  logic [31:0] m0_addr,
   input  logic [3:0]  m0_mask,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   output logic        m0_ack,
   input  logic        m1_req,
   input  logic        m1_we,
   input  logic [31:0] m1_addr,
   input  logic [3:0]  m1_mask,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        m1_ack,
   output logic        hold_o,
   output logic [31:0] perip_addr,
   output logic        perip_wen,
   output logic [3:0]  perip_mask,
   output logic [31:0] perip_wdata,
   input  logic [31:0] perip_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   localparam logic [1:0] CNT_INIT  = 2'(RD_LAT - 1);
   localparam bit         SKIP_WAIT = (RD_LAT == 1);

   state_t      state_q, state_d;
   logic        grant_q, grant_d;   // 0 = master 0, 1 = master 1; doubles as last_grant
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [3:0]  mask_q, mask_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  cnt_q, cnt_d;
   logic [31:0] m0_rdata_q, m0_rdata_d;
   logic [31:0] m1_rdata_q, m1_rdata_d;
   logic        win;
   logic        is_issue;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path can infer a latch.
      state_d    = state_q;
      grant_d    = grant_q;
      we_d       = we_q;
      addr_d     = addr_q;
      mask_d     = mask_q;
      wdata_d    = wdata_q;
      cnt_d      = cnt_q;
      m0_rdata_d = m0_rdata_q;
      m1_rdata_d = m1_rdata_q;

      win = m1_req;
      if (m0_req && m1_req) win = ~grant_q;

      case (state_q)
         IDLE: begin
            if (m0_req || m1_req) begin
               grant_d = win;
               we_d    = win ? m1_we    : m0_we;
               addr_d  = win ? m1_addr  : m0_addr;
               mask_d  = win ? m1_mask  : m0_mask;
               wdata_d = win ? m1_wdata : m0_wdata;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            if (we_q) begin
               state_d = DONE;
            end else begin
               cnt_d   = CNT_INIT;
               state_d = SKIP_WAIT ? DONE : WAIT;
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 2'd1;
            if (cnt_q == 2'd1) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Read data is taken on the edge that enters DONE.
      if (state_d == DONE && !we_q) begin
         if (grant_q) m1_rdata_d = perip_rdata;
         else         m0_rdata_d = perip_rdata;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= 1'b1;
         we_q       <= 1'b0;
         addr_q     <= '0;
         mask_q     <= '0;
         wdata_q    <= '0;
         cnt_q      <= '0;
         m0_rdata_q <= '0;
         m1_rdata_q <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         mask_q     <= mask_d;
         wdata_q    <= wdata_d;
         cnt_q      <= cnt_d;
         m0_rdata_q <= m0_rdata_d;
         m1_rdata_q <= m1_rdata_d;
      end
   end

   assign is_issue    = (state_q == ISSUE);
   assign perip_addr  = is_issue ? addr_q  : '0;
   assign perip_mask  = is_issue ? mask_q  : '0;
   assign perip_wdata = is_issue ? wdata_q : '0;
   assign perip_wen   = is_issue & we_q;

   assign m0_ack   = (state_q == DONE) & ~grant_q;
   assign m1_ack   = (state_q == DONE) &  grant_q;
   assign m0_rdata = m0_rdata_q;
   assign m1_rdata = m1_rdata_q;
   assign hold_o   = m0_req & ~m0_ack;

endmodule
